// File: rtl/info_trace_tx_pkg.sv
// info_trace_tx_pkg: shared sync byte, FSM states, header field layout and record type for the trace transmitter.
package info_trace_tx_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hD5;
    localparam int HDR_SYNC_HI = 31;
    localparam int HDR_SYNC_LO = 24;
    localparam int HDR_SEQ_HI = 23;
    localparam int HDR_SEQ_LO = 16;
    localparam int HDR_WE = 7;
    localparam int HDR_A3_HI = 4;
    localparam int HDR_A3_LO = 0;

    typedef enum logic [1:0] {IDLE, HDR, PC, DATA} state_t;

    typedef struct packed {
        logic [7:0]  seq;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] pc;
        logic [31:0] wd;
    } rec_t;

    function automatic logic [31:0] hdr_word(input rec_t r);
        logic [31:0] w;
        w = '0;
        w[HDR_SYNC_HI:HDR_SYNC_LO] = SYNC_BYTE;
        w[HDR_SEQ_HI:HDR_SEQ_LO] = r.seq;
        w[HDR_WE] = r.we;
        w[HDR_A3_HI:HDR_A3_LO] = r.a3;
        return w;
    endfunction
endpackage

// File: rtl/info_trace_tx_fifo.sv
// info_trace_tx_fifo: DEPTH-entry record FIFO with same-cycle push/pop and combinational head and second-entry outputs.
module info_trace_tx_fifo
    import info_trace_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  rec_t                   din_i,
    output rec_t                   head_o,
    output rec_t                   next_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    rec_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= push_i ? wr_q + AW'(1) : wr_q;
            rd_q <= pop_i ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    assign head_o = mem_q[rd_q];
    assign next_o = mem_q[rd_q + AW'(1)];
    assign count_o = cnt_q;
endmodule

// File: rtl/info_trace_tx.sv
// info_trace_tx: buffers W-stage retirements and streams each as header/PC/WD words over valid/ready.
// Define TRACE_WRITES_ONLY_EN to trace only retirements that write a nonzero GRF register.
module info_trace_tx
    import info_trace_tx_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [4:0]             in_a3,
    input  logic [31:0]            in_wd,
    input  logic                   in_we,
    output logic                   tx_valid,
    output logic [31:0]            tx_data,
    output logic                   tx_last,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic [DROP_W-1:0]      drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t state_q, state_d;
    logic tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [7:0] seq_q, seq_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic cand, xfer, pop, push, drop, have_nxt;
    rec_t rec_in, head, nxt, nxt_rec;

`ifdef TRACE_WRITES_ONLY_EN
    assign cand = in_valid && in_we && (in_a3 != 5'd0);
`else
    assign cand = in_valid;
`endif

    assign rec_in = {seq_q, in_we, in_a3, in_pc, in_wd};
    assign xfer = tx_valid_q && tx_ready;
    assign pop = xfer && (state_q == DATA);
    assign push = cand && ((count < FULL) || pop);
    assign drop = cand && !push;
    // When the FIFO would otherwise be empty, the next header comes straight from this cycle's push.
    assign have_nxt = push || ((state_q == DATA) ? (count > CW'(1)) : (count != '0));
    assign nxt_rec = (state_q == DATA) ? ((count > CW'(1)) ? nxt : rec_in)
                                       : ((count != '0) ? head : rec_in);

    info_trace_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push_i(push),
        .pop_i(pop),
        .din_i(rec_in),
        .head_o(head),
        .next_o(nxt),
        .count_o(count)
    );

    always_comb begin
        state_d = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d = tx_data_q;
        tx_last_d = tx_last_q;
        case (state_q)
            IDLE: if (have_nxt) begin
                state_d = HDR;
                tx_valid_d = 1'b1;
                tx_data_d = hdr_word(nxt_rec);
            end
            HDR: if (xfer) begin
                state_d = PC;
                tx_data_d = head.pc;
            end
            PC: if (xfer) begin
                state_d = DATA;
                tx_data_d = head.wd;
                tx_last_d = 1'b1;
            end
            DATA: if (xfer) begin
                state_d = have_nxt ? HDR : IDLE;
                tx_valid_d = have_nxt;
                tx_data_d = have_nxt ? hdr_word(nxt_rec) : '0;
                tx_last_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        seq_d = seq_q + 8'(push);
        drop_d = (drop && !(&drop_q)) ? drop_q + DROP_W'(1) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q <= '0;
            tx_last_q <= 1'b0;
            seq_q <= '0;
            drop_q <= '0;
        end else begin
            state_q <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q <= tx_data_d;
            tx_last_q <= tx_last_d;
            seq_q <= seq_d;
            drop_q <= drop_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data = tx_data_q;
    assign tx_last = tx_last_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_info_trace_tx.sv
// tb_info_trace_tx: table-driven single records plus scoreboarded backpressure, overflow, wrap and reset sequences.
module tb_info_trace_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_we = 1'b0, tx_ready = 1'b0;
    logic [31:0] in_pc = '0, in_wd = '0;
    logic [4:0] in_a3 = '0;
    logic tx_valid, tx_last;
    logic [31:0] tx_data;
    logic [3:0] count;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [7:0] mseq = '0;
    logic [15:0] mdrop = '0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        we;
        logic [31:0] hdr;
    } vec_t;
    vec_t tv[4];

    always #5 clk = ~clk;

    info_trace_tx dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_a3(in_a3),
        .in_wd(in_wd), .in_we(in_we), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .count(count), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: a word transfers at the coming edge, so compare it at the negedge before.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h expected=none", tx_data);
            end else begin
                chk("stream_last", 32'(tx_last), 32'(exp_q.size() % 3 == 1));
                chk("stream_word", tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] a3,
                        input logic [31:0] wd, input logic we, input logic rdy);
        logic pop_now;
        @(posedge clk);
        #1;
        in_valid = v; in_pc = pc; in_a3 = a3; in_wd = wd; in_we = we; tx_ready = rdy;
        if (v) begin
            pop_now = rdy && (exp_q.size() % 3 == 1);
            if (((exp_q.size() + 2) / 3) < 8 || pop_now) begin
                exp_q.push_back({8'hD5, mseq, 8'h00, we, 2'b00, a3});
                exp_q.push_back(pc);
                exp_q.push_back(wd);
                mseq++;
            end else if (mdrop != 16'hFFFF) begin
                mdrop++;
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, '0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b0; tx_ready = 1'b0;
        exp_q.delete(); mseq = '0; mdrop = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(1'b1);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_valid", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        tv[0] = '{32'h0000_3000, 5'd5,  32'h0000_1234, 1'b1, 32'hD500_0085};
        tv[1] = '{32'h0000_4004, 5'd31, 32'hFFFF_FFFF, 1'b0, 32'hD501_001F};
        tv[2] = '{32'h0000_0000, 5'd0,  32'h0000_0000, 1'b1, 32'hD502_0080};
        tv[3] = '{32'h1234_5678, 5'd17, 32'hDEAD_BEEF, 1'b1, 32'hD503_0091};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", tx_data, 32'd0);
        chk("rst_last", 32'(tx_last), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step(1'b1, tv[i].pc, tv[i].a3, tv[i].wd, tv[i].we, 1'b1);
            chk("vec_pre_valid", 32'(tx_valid), 32'd0);
            idle(1'b1);
            chk("vec_hdr", tx_data, tv[i].hdr);
            chk("vec_hdr_valid", 32'(tx_valid), 32'd1);
            chk("vec_hdr_last", 32'(tx_last), 32'd0);
            idle(1'b1);
            chk("vec_pc", tx_data, tv[i].pc);
            chk("vec_pc_last", 32'(tx_last), 32'd0);
            idle(1'b1);
            chk("vec_wd", tx_data, tv[i].wd);
            chk("vec_wd_last", 32'(tx_last), 32'd1);
            idle(1'b1);
            chk("vec_post_valid", 32'(tx_valid), 32'd0);
        end

        step(1'b1, 32'h0000_7000, 5'd2, 32'h0000_0777, 1'b1, 1'b1);
        idle(1'b1);
        chk("bp_hdr", tx_data, 32'hD504_0082);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("bp_hold_data", tx_data, 32'h0000_7000);
            chk("bp_hold_valid", 32'(tx_valid), 32'd1);
            chk("bp_hold_last", 32'(tx_last), 32'd0);
        end
        idle(1'b1);
        chk("bp_resume", tx_data, 32'h0000_7000);
        drain();

        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h0000_0100 + 32'(i), 5'(i + 1), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
        idle(1'b0);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_model_drop", 32'(drop_cnt), 32'(mdrop));
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 32'h0000_0F00, 5'd7, 32'h0000_F0F0, 1'b1, 1'b1);
        idle(1'b1);
        chk("fullpop_count", 32'(count), 32'd8);
        chk("fullpop_drop", 32'(drop_cnt), 32'd2);
        drain();
        chk("ovf_end_drop", 32'(drop_cnt), 32'(mdrop));

        step(1'b1, 32'h0000_5000, 5'd3, 32'h0000_00AA, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("rmid_pc", tx_data, 32'h0000_5000);
        reset = 1'b1;
        exp_q.delete(); mseq = '0; mdrop = '0;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("rmid_valid", 32'(tx_valid), 32'd0);
        chk("rmid_count", 32'(count), 32'd0);
        chk("rmid_drop", 32'(drop_cnt), 32'd0);
        step(1'b1, 32'h0000_6000, 5'd9, 32'h0000_00BB, 1'b1, 1'b1);
        idle(1'b1);
        chk("rmid_seq0_hdr", tx_data, 32'hD500_0089);
        drain();

        do_reset();
        for (int i = 0; i < 258; i++) begin
            step(1'b1, 32'(i * 4), 5'(i), ~32'(i), 1'b1, 1'b1);
            idle(1'b1);
            if (i == 255) chk("wrap_ff", 32'(tx_data[23:16]), 32'hFF);
            if (i == 256) chk("wrap_00", 32'(tx_data[23:16]), 32'h00);
            if (i == 257) chk("wrap_01", 32'(tx_data[23:16]), 32'h01);
            idle(1'b1);
        end
        drain();
        chk("wrap_drop", 32'(drop_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
